// File: rtl/sync_transmitter_baud.sv
// Serial byte transmitter (start, 8 data bits LSB first, stop) paced by a free-running baud divider.
// Define SYNC_TX_PARITY_EN to insert an even-parity bit between the data bits and the stop bit.
module sync_transmitter_baud #(
    parameter int BAUD_DIV = 25
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       CLR,
    input  logic [7:0] Data9,
    output logic       CLK_Baud,
    output logic       OUT_ser
);

`ifdef SYNC_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

    localparam logic [15:0] LAST = 16'(BAUD_DIV - 1);

    state_t      state;
    logic [15:0] baud_cnt;
    logic [15:0] baud_nxt;
    logic [2:0]  bit_idx;
    logic [2:0]  idx_nxt;
    logic [7:0]  shreg;
    logic        accept;
    logic        bit_end;

    assign accept  = (state == IDLE) && CLR;
    assign bit_end = (baud_cnt == LAST);
    assign idx_nxt = bit_idx + 3'd1;

    // A new frame restarts the divider so the start bit lasts a full period.
    always_comb begin
        baud_nxt = baud_cnt + 16'd1;
        if (accept || bit_end)
            baud_nxt = 16'd0;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= IDLE;
            baud_cnt <= 16'd0;
            bit_idx  <= 3'd0;
            shreg    <= 8'd0;
            CLK_Baud <= 1'b0;
            OUT_ser  <= 1'b1;
        end else begin
            baud_cnt <= baud_nxt;
            CLK_Baud <= (baud_nxt == LAST);
            case (state)
                IDLE: begin
                    OUT_ser <= 1'b1;
                    if (CLR) begin
                        shreg   <= Data9;
                        bit_idx <= 3'd0;
                        state   <= START;
                        OUT_ser <= 1'b0;
                    end
                end
                START: begin
                    if (bit_end) begin
                        state   <= DATA;
                        OUT_ser <= shreg[0];
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        if (bit_idx == 3'd7) begin
                            bit_idx <= 3'd0;
`ifdef SYNC_TX_PARITY_EN
                            state   <= PARITY;
                            OUT_ser <= ^shreg;
`else
                            state   <= STOP;
                            OUT_ser <= 1'b1;
`endif
                        end else begin
                            bit_idx <= idx_nxt;
                            OUT_ser <= shreg[idx_nxt];
                        end
                    end
                end
`ifdef SYNC_TX_PARITY_EN
                PARITY: begin
                    if (bit_end) begin
                        state   <= STOP;
                        OUT_ser <= 1'b1;
                    end
                end
`endif
                STOP: begin
                    // A start request on this edge is ignored; IDLE takes it next edge.
                    if (bit_end) begin
                        state   <= IDLE;
                        OUT_ser <= 1'b1;
                    end
                end
                default: begin
                    state   <= IDLE;
                    OUT_ser <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sync_transmitter_baud.sv
module tb_sync_transmitter_baud;

    localparam int BAUD = 25;
`ifdef SYNC_TX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    localparam int FRAME = NBITS * BAUD;

    logic       CLK;
    logic       RST;
    logic       CLR;
    logic [7:0] Data9;
    logic       CLK_Baud;
    logic       OUT_ser;

    int checks = 0;
    int errors = 0;

    sync_transmitter_baud #(.BAUD_DIV(BAUD)) dut (
        .CLK      (CLK),
        .RST      (RST),
        .CLR      (CLR),
        .Data9    (Data9),
        .CLK_Baud (CLK_Baud),
        .OUT_ser  (OUT_ser)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input int idx, input logic got, input logic exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s[%0d] observed %b expected %b", tag, idx, got, exp);
        end
    endtask

    // Line level for bit period k of a frame carrying byte b.
    function automatic logic exp_bit(input logic [7:0] b, input int k);
        if (k == 0)
            return 1'b0;
        if (k <= 8)
            return b[k-1];
`ifdef SYNC_TX_PARITY_EN
        if (k == 9)
            return ^b;
`endif
        return 1'b1;
    endfunction

    // Entered at the sample just after the accepting edge; leaves at the last stop-bit sample.
    task automatic frame_check(input logic [7:0] b, input int clr_at, input logic [7:0] d_after);
        for (int j = 0; j < FRAME; j++) begin
            chk("out_ser", j, OUT_ser, exp_bit(b, j / BAUD));
            chk("clk_baud", j, CLK_Baud, (j % BAUD) == (BAUD - 1));
            if (j == 1)
                Data9 = d_after;
            CLR = (j == clr_at);
            if (j < FRAME - 1)
                tick();
        end
        CLR = 1'b0;
    endtask

    initial begin
        RST   = 1'b1;
        CLR   = 1'b0;
        Data9 = 8'h00;
        tick();
        tick();
        chk("rst_out", 0, OUT_ser, 1'b1);
        chk("rst_baud", 0, CLK_Baud, 1'b0);
        RST = 1'b0;

        // Idle: line stays high, divider pulses once every BAUD cycles.
        for (int i = 0; i < 2 * BAUD; i++) begin
            tick();
            chk("idle_out", i, OUT_ser, 1'b1);
            chk("idle_baud", i, CLK_Baud, (i % BAUD) == (BAUD - 2));
        end

        // Frame 0x14; Data9 moves to 0x46 one cycle after acceptance.
        Data9 = 8'h14;
        CLR   = 1'b1;
        tick();
        CLR   = 1'b0;
        frame_check(8'h14, -1, 8'h46);

        // Start held across the stop-completing edge: ignored there, taken next edge.
        CLR = 1'b1;
        tick();
        chk("stop_edge_clr", 0, OUT_ser, 1'b1);
        tick();
        chk("accept_after_stop", 0, OUT_ser, 1'b0);
        CLR = 1'b0;

        // Frame 0x46 with a start strobe during data bit 3.
        frame_check(8'h46, 4 * BAUD + 5, 8'h46);
        for (int i = 0; i < 30; i++) begin
            tick();
            chk("no_second_frame", i, OUT_ser, 1'b1);
        end

        // Reset during data bit 4, with CLR asserted alongside it.
        Data9 = 8'hA5;
        CLR   = 1'b1;
        tick();
        CLR   = 1'b0;
        chk("abort_start", 0, OUT_ser, 1'b0);
        for (int i = 0; i < 5 * BAUD + 10; i++)
            tick();
        chk("abort_bit4", 0, OUT_ser, 1'b0);
        RST = 1'b1;
        CLR = 1'b1;
        tick();
        chk("abort_out", 0, OUT_ser, 1'b1);
        chk("abort_baud", 0, CLK_Baud, 1'b0);
        RST = 1'b0;
        CLR = 1'b0;
        tick();
        chk("abort_idle", 0, OUT_ser, 1'b1);

        Data9 = 8'h3C;
        CLR   = 1'b1;
        tick();
        CLR   = 1'b0;
        frame_check(8'h3C, -1, 8'hFF);
        tick();
        chk("final_idle", 0, OUT_ser, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
